// File: rtl/corelet_ctrl_pkg.sv
// Shared definitions for the corelet controller: FSM state encoding and the
// bit positions of the fields driven in the 35-bit corelet instruction word.
package corelet_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KPUSH,
        S_GAP,
        S_XLOAD,
        S_EXEC,
        S_PSUM,
        S_DRAIN
    } state_t;

    localparam int INST_W        = 35;
    localparam int INST_PSUM     = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_EXEC     = 1;
    localparam int INST_KLOAD    = 0;

endpackage

// File: rtl/corelet_ctrl_counter.sv
// Phase counter for the corelet controller: loadable up-counter with enable
// and clear, plus an exact terminal-count match (no wrap-based compare).
module ctrl_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic         hit
);

    logic [W-1:0] cnt_reg;

    // Count register: clear beats load, load beats increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign hit = (cnt_reg == term);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet run sequencer: kernel load/push, activation load, execute, psum
// transfer and output drain. Every output is registered, so each output
// reflects the FSM decision taken on the previous clock edge.
// Optional feature: define CORELET_CTRL_OS_EN to enable output-stationary
// runs (mode=1) and the PSUM phase; otherwise every run is weight-stationary.
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [len_bw-1:0] len,
    input  logic              src_valid,
    input  logic              l0_o_full,
    input  logic              ififo_o_full,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              l0_wr,
    output logic              ififo_wr,
    output logic              src_rd,
    output logic              busy,
    output logic              done
);

`ifdef CORELET_CTRL_OS_EN
    localparam bit OS_EN = 1'b1;
`else
    localparam bit OS_EN = 1'b0;
`endif

    // One extra bit keeps row+col and len terminal values free of wrap-around.
    localparam int CW = len_bw + 1;
    localparam logic [CW-1:0] ROW_TERM   = CW'(row - 1);
    localparam logic [CW-1:0] COL_TERM   = CW'(col - 1);
    localparam logic [CW-1:0] KPUSH_TERM = CW'(row + col - 1);

    state_t              state_reg, state_next;
    logic                mode_reg, mode_next;
    logic [len_bw-1:0]   len_reg, len_next;
    logic [INST_W-1:0]   inst_reg, inst_next;
    logic                l0_wr_reg, l0_wr_next;
    logic                ififo_wr_reg, ififo_wr_next;
    logic                src_rd_reg, src_rd_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                mode_eff, os_run, l0_accept, x_accept;
    logic                cnt_en, cnt_clr, cnt_hit;
    logic [CW-1:0]       cnt_term, len_term;

    assign mode_eff  = OS_EN & mode;
    assign os_run    = OS_EN & mode_reg;
    assign len_term  = {1'b0, len_reg} - CW'(1);
    assign l0_accept = src_valid && !l0_o_full;
    // OS activation writes land in both L0 and the IFIFO, so both must have room.
    assign x_accept  = l0_accept && !(os_run && ififo_o_full);
    assign cnt_clr   = (state_next != state_reg);

    ctrl_counter #(.W(CW)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .load     (1'b0),
        .load_val ('0),
        .term     (cnt_term),
        .hit      (cnt_hit)
    );

    // Next-state, phase counting and next-cycle output decisions.
    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        len_next      = len_reg;
        inst_next     = '0;
        l0_wr_next    = 1'b0;
        ififo_wr_next = 1'b0;
        src_rd_next   = 1'b0;
        done_next     = 1'b0;
        cnt_en        = 1'b0;
        cnt_term      = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        mode_next  = mode_eff;
                        len_next   = len;
                        state_next = mode_eff ? S_XLOAD : S_KLOAD;
                    end
                end
            end
            S_KLOAD: begin
                cnt_term = ROW_TERM;
                if (l0_accept) begin
                    l0_wr_next  = 1'b1;
                    src_rd_next = 1'b1;
                    cnt_en      = 1'b1;
                    if (cnt_hit) state_next = S_KPUSH;
                end
            end
            S_KPUSH: begin
                inst_next[INST_L0_RD] = 1'b1;
                inst_next[INST_KLOAD] = 1'b1;
                cnt_term = KPUSH_TERM;
                cnt_en   = 1'b1;
                if (cnt_hit) state_next = S_GAP;
            end
            S_GAP: begin
                state_next = S_XLOAD;
            end
            S_XLOAD: begin
                cnt_term = len_term;
                if (x_accept) begin
                    l0_wr_next    = 1'b1;
                    src_rd_next   = 1'b1;
                    ififo_wr_next = os_run;
                    cnt_en        = 1'b1;
                    if (cnt_hit) state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_next[INST_L0_RD]    = 1'b1;
                inst_next[INST_EXEC]     = 1'b1;
                inst_next[INST_IFIFO_RD] = os_run;
                cnt_term = len_term;
                cnt_en   = 1'b1;
                if (cnt_hit) state_next = os_run ? S_PSUM : S_DRAIN;
            end
            S_PSUM: begin
                inst_next[INST_PSUM] = OS_EN;
                cnt_term = ROW_TERM;
                cnt_en   = 1'b1;
                if (cnt_hit) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                inst_next[INST_OFIFO_RD] = ofifo_valid;
                inst_next[INST_ACC]      = OS_EN && ofifo_valid;
                cnt_term = os_run ? COL_TERM : len_term;
                if (ofifo_valid) begin
                    cnt_en = 1'b1;
                    if (cnt_hit) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    // State, latched run parameters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            mode_reg     <= 1'b0;
            len_reg      <= '0;
            inst_reg     <= '0;
            l0_wr_reg    <= 1'b0;
            ififo_wr_reg <= 1'b0;
            src_rd_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            len_reg      <= len_next;
            inst_reg     <= inst_next;
            l0_wr_reg    <= l0_wr_next;
            ififo_wr_reg <= ififo_wr_next;
            src_rd_reg   <= src_rd_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign inst     = inst_reg;
    assign l0_wr    = l0_wr_reg;
    assign ififo_wr = ififo_wr_reg;
    assign src_rd   = src_rd_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl. Each run is summarised as a phase
// string (W=l0 write, K=kernel push, X=execute, P=psum, R=drain read, with
// run lengths, idle cycles dropped) and compared with the sequence the run
// rules predict. Outputs are registered, so an output seen after edge N is
// judged against the inputs that were applied before edge N.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int LBW = 8;
`ifdef CORELET_CTRL_OS_EN
    localparam bit OS_BUILD = 1'b1;
`else
    localparam bit OS_BUILD = 1'b0;
`endif

    localparam logic [34:0] ALLOWED = 35'h6_0000_005B;
    localparam logic [34:0] K_PAT   = 35'h0_0000_0009;
    localparam logic [34:0] X_WS    = 35'h0_0000_000A;
    localparam logic [34:0] X_OS    = 35'h0_0000_001A;
    localparam logic [34:0] P_PAT   = 35'h4_0000_0000;
    localparam logic [34:0] R_PAT   = 35'h0_0000_0040;
    localparam logic [34:0] R_ACC   = 35'h2_0000_0040;

    logic           clk, reset, start, mode;
    logic [LBW-1:0] len;
    logic           src_valid, l0_o_full, ififo_o_full, ofifo_valid;
    logic [34:0]    inst;
    logic           l0_wr, ififo_wr, src_rd, busy, done;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent run.
    string obs_seg, obs_msg;
    int    obs_viol, obs_busy, obs_extra, obs_fullw, obs_ififo;
    bit    obs_done, obs_timeout;

    corelet_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
        .src_valid(src_valid), .l0_o_full(l0_o_full), .ififo_o_full(ififo_o_full),
        .ofifo_valid(ofifo_valid), .inst(inst), .l0_wr(l0_wr), .ififo_wr(ififo_wr),
        .src_rd(src_rd), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string exp_seg(input bit os, input int n);
        if (n == 0) return "";
        if (os) return $sformatf("W%0dX%0dP%0dR%0d", n, n, ROW, COL);
        return $sformatf("W%0dK%0dW%0dX%0dR%0d", ROW, ROW + COL, n, n, n);
    endfunction

    task automatic note(input string msg);
        if (obs_viol == 0) obs_msg = msg;
        obs_viol++;
    endtask

    task automatic drive_inputs(input int pv, input int pfull, input int pov, input bit force_full);
        src_valid    = ($urandom_range(99) < pv);
        l0_o_full    = force_full || ($urandom_range(99) < pfull);
        ififo_o_full = ($urandom_range(99) < pfull);
        ofifo_valid  = ($urandom_range(99) < pov);
    endtask

    // Launch a run and observe it until done (bounded); entered and left at posedge+1.
    task automatic run(input bit m, input int n, input int pv, input int pfull, input int pov,
                       input int full_from, input int full_len, input bit poke);
        bit    os, p_sv, p_lf, p_if, p_ov, poked;
        string tag, cur, prev_tag;
        int    runlen, cyc;
        os = OS_BUILD && m;
        obs_seg = ""; obs_msg = ""; obs_viol = 0; obs_busy = 0; obs_extra = 0;
        obs_fullw = 0; obs_ififo = 0; obs_done = 0; obs_timeout = 0;
        cur = ""; prev_tag = "Z"; runlen = 0; cyc = 0; poked = 0;
        mode = m; len = LBW'(n); start = 1'b1;
        drive_inputs(pv, pfull, pov, 1'b0);
        p_sv = src_valid; p_lf = l0_o_full; p_if = ififo_o_full; p_ov = ofifo_valid;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 4000) begin
            tag = "Z";
            if (busy) obs_busy++;
            if ((inst & ~ALLOWED) != '0) note("illegal inst bit");
            if (src_rd !== l0_wr) note("src_rd differs from l0_wr");
            if (ififo_wr !== (os && l0_wr)) note("ififo_wr not paired with l0_wr");
            if (ififo_wr) obs_ififo++;
            if (l0_wr) begin
                tag = "W";
                if (p_lf) obs_fullw++;
                if (!p_sv || p_lf) note("l0 write without accepted source");
                if (os && p_if) note("ififo write while full");
                if (inst != '0) note("write overlaps instruction");
            end else if (inst == K_PAT) begin
                tag = "K";
            end else if (inst == (os ? X_OS : X_WS)) begin
                tag = "X";
            end else if (inst == P_PAT) begin
                tag = "P";
            end else if (inst[6]) begin
                tag = "R";
                if (inst !== (OS_BUILD ? R_ACC : R_PAT)) note("drain read inst pattern");
                if (!p_ov) note("read without ofifo_valid");
            end else if (inst != '0) begin
                note("unexpected inst pattern");
            end
            if (prev_tag == "K" && tag != "K" && tag != "Z") note("no gap after kernel push");
            prev_tag = tag;
            if (tag != "Z") begin
                if (tag == cur) runlen++;
                else begin
                    if (runlen > 0) obs_seg = $sformatf("%s%s%0d", obs_seg, cur, runlen);
                    cur = tag; runlen = 1;
                end
            end
            if (done) begin
                obs_done = 1;
                if (busy) note("busy together with done");
                if (n != 0 && tag != "R") note("done not on final read");
                break;
            end else if (!busy) begin
                note("busy dropped mid-run");
            end
            start = 1'b0;
            if (poke && !poked && tag == "X") begin
                start = 1'b1; mode = ~m; len = LBW'(3); poked = 1;
            end
            drive_inputs(pv, pfull, pov, (cyc >= full_from) && (cyc < full_from + full_len));
            p_sv = src_valid; p_lf = l0_o_full; p_if = ififo_o_full; p_ov = ofifo_valid;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (runlen > 0) obs_seg = $sformatf("%s%s%0d", obs_seg, cur, runlen);
        if (!obs_done) obs_timeout = 1;
        repeat (3) begin
            drive_inputs(pv, pfull, pov, 1'b0);
            @(posedge clk); #1;
            if (done || busy || inst != '0 || l0_wr || src_rd || ififo_wr) obs_extra++;
        end
        $display("run mode=%0d len=%0d seq=%s viol=%0d cycles=%0d", m, n, obs_seg, obs_viol, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mode = 1'b0; len = '0;
        src_valid = 1'b0; l0_o_full = 1'b0; ififo_o_full = 1'b0; ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (inst !== '0) begin errors++; $display("FAIL reset.inst got=%h want=0", inst); end
        checks++;
        if ({l0_wr, ififo_wr, src_rd, busy, done} !== 5'b0)
            begin errors++; $display("FAIL reset.strobes got=%b want=00000", {l0_wr, ififo_wr, src_rd, busy, done}); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, l0_wr} !== 3'b0) begin errors++; $display("FAIL reset.idle got=%b want=000", {busy, done, l0_wr}); end
    endtask

    task automatic test_ws_basic();
        string e;
        e = exp_seg(1'b0, 4);
        run(1'b0, 4, 100, 0, 100, -1, 0, 1'b0);
        checks++;
        if (obs_seg != e) begin errors++; $display("FAIL ws_basic.seq got=%s want=%s", obs_seg, e); end
        checks++;
        if (obs_viol !== 0) begin errors++; $display("FAIL ws_basic.rules got=%0d (%s) want=0", obs_viol, obs_msg); end
        checks++;
        if (obs_done !== 1'b1 || obs_extra !== 0)
            begin errors++; $display("FAIL ws_basic.done got=%0d/%0d want=1/0", obs_done, obs_extra); end
    endtask

    task automatic test_os_basic();
        string e;
        e = exp_seg(OS_BUILD, 3);
        run(1'b1, 3, 100, 0, 100, -1, 0, 1'b0);
        checks++;
        if (obs_seg != e) begin errors++; $display("FAIL os_basic.seq got=%s want=%s", obs_seg, e); end
        checks++;
        if (obs_viol !== 0) begin errors++; $display("FAIL os_basic.rules got=%0d (%s) want=0", obs_viol, obs_msg); end
        checks++;
        if (obs_ififo !== (OS_BUILD ? 3 : 0))
            begin errors++; $display("FAIL os_basic.ififo got=%0d want=%0d", obs_ififo, OS_BUILD ? 3 : 0); end
    endtask

    task automatic test_mode1_len2();
        string e;
        e = exp_seg(OS_BUILD, 2);
        run(1'b1, 2, 100, 0, 100, -1, 0, 1'b0);
        checks++;
        if (obs_seg != e) begin errors++; $display("FAIL mode1_len2.seq got=%s want=%s", obs_seg, e); end
        checks++;
        if (obs_ififo !== (OS_BUILD ? 2 : 0))
            begin errors++; $display("FAIL mode1_len2.ififo got=%0d want=%0d", obs_ififo, OS_BUILD ? 2 : 0); end
    endtask

    task automatic test_full_stall();
        string e;
        e = exp_seg(1'b0, 4);
        run(1'b0, 4, 100, 0, 100, 2, 5, 1'b0);
        checks++;
        if (obs_seg != e) begin errors++; $display("FAIL full_stall.seq got=%s want=%s", obs_seg, e); end
        checks++;
        if (obs_fullw !== 0) begin errors++; $display("FAIL full_stall.write_when_full got=%0d want=0", obs_fullw); end
        checks++;
        if (obs_viol !== 0) begin errors++; $display("FAIL full_stall.rules got=%0d (%s) want=0", obs_viol, obs_msg); end
    endtask

    task automatic test_len_zero();
        run(1'b0, 0, 100, 0, 100, -1, 0, 1'b0);
        checks++;
        if (obs_done !== 1'b1) begin errors++; $display("FAIL len_zero.done got=%0d want=1", obs_done); end
        checks++;
        if (obs_busy !== 0) begin errors++; $display("FAIL len_zero.busy got=%0d want=0", obs_busy); end
        checks++;
        if (obs_seg != "" || obs_extra !== 0)
            begin errors++; $display("FAIL len_zero.activity got=%s/%0d want=(empty)/0", obs_seg, obs_extra); end
    endtask

    task automatic test_start_ignored();
        string e;
        e = exp_seg(1'b0, 5);
        run(1'b0, 5, 100, 0, 100, -1, 0, 1'b1);
        checks++;
        if (obs_seg != e) begin errors++; $display("FAIL start_ignored.seq got=%s want=%s", obs_seg, e); end
        checks++;
        if (obs_extra !== 0) begin errors++; $display("FAIL start_ignored.after_done got=%0d want=0", obs_extra); end
    endtask

    task automatic test_reset_mid_run();
        bit    seen;
        string e;
        mode = 1'b0; len = LBW'(5); start = 1'b1;
        drive_inputs(100, 0, 100, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (inst[1]) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_reset.reach_exec got=0 want=1"); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({inst, l0_wr, ififo_wr, src_rd, busy, done} !== 40'b0)
            begin errors++; $display("FAIL mid_reset.outputs got=%h/%b want=0", inst, {l0_wr, ififo_wr, src_rd, busy, done}); end
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (done || busy) seen = 1; end
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (done || busy) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_reset.no_done got=1 want=0"); end
        e = exp_seg(1'b0, 2);
        run(1'b0, 2, 100, 0, 100, -1, 0, 1'b0);
        checks++;
        if (obs_seg != e || obs_viol !== 0)
            begin errors++; $display("FAIL mid_reset.rerun got=%s/%0d want=%s/0", obs_seg, obs_viol, e); end
    endtask

    task automatic test_random();
        bit    m;
        int    n;
        string e;
        for (int k = 0; k < 6; k++) begin
            m = 1'($urandom_range(1));
            n = int'($urandom_range(12, 1));
            e = exp_seg(OS_BUILD && m, n);
            run(m, n, int'($urandom_range(100, 40)), int'($urandom_range(40)),
                int'($urandom_range(100, 30)), -1, 0, 1'b0);
            checks++;
            if (obs_seg != e) begin errors++; $display("FAIL random%0d.seq got=%s want=%s", k, obs_seg, e); end
            checks++;
            if (obs_viol !== 0 || obs_timeout) begin
                errors++;
                $display("FAIL random%0d.rules got=%0d (%s) timeout=%0d want=0", k, obs_viol, obs_msg, obs_timeout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ws_basic();
        test_os_basic();
        test_mode1_len2();
        test_full_stall();
        test_len_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning PE rows / L0 depth unit.
REQ-002 SHALL have parameter col, default 8, meaning PE columns / OFIFO width.
REQ-003 SHALL have parameter len_bw, default 8, meaning width of the vector-count field.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that launches a run; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 1 bit: run type, 0 = weight-stationary (WS), 1 = output-stationary (OS); latched at start.
REQ-008 SHALL have port len, input, len_bw bits: number of activation vectors per run, latched at start.
REQ-009 SHALL have port src_valid, input, 1 bit: the upstream vector is available this cycle.
REQ-010 SHALL have ports l0_o_full, ififo_o_full and ofifo_valid, inputs, 1 bit each: corelet FIFO status.
REQ-011 SHALL have port inst, output, 35 bits: the corelet instruction word.
REQ-012 SHALL have ports l0_wr, ififo_wr and src_rd, outputs, 1 bit each: FIFO writes and the upstream pop.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each: status.

Function
REQ-014 SHALL use only these inst bits: [34] psum-transfer mode, [33] acc, [6] ofifo_rd, [4] ififo_rd, [3] l0_rd, [1] execute, [0] kernel load; all other bits SHALL be 0.
REQ-015 SHALL implement the states IDLE, KLOAD, KPUSH, GAP, XLOAD, EXEC, PSUM and DRAIN.
REQ-016 IDLE: start=1 and len!=0 SHALL go to KLOAD when mode=0 and to XLOAD when mode=1.
REQ-017 IDLE: start=1 with len=0 SHALL pulse done for one cycle and stay in IDLE.
REQ-018 KLOAD: l0_wr=src_rd=src_valid&&!l0_o_full; it SHALL leave after row accepted writes, going to KPUSH.
REQ-019 KPUSH: inst[3]=inst[0]=1 for exactly col+row cycles, then go to GAP.
REQ-020 GAP: every output SHALL be 0 for one cycle, then go to XLOAD.
REQ-021 XLOAD in WS: SHALL write l0 under the KLOAD rule until len writes are accepted.
REQ-022 XLOAD in OS: each write SHALL require src_valid&&!l0_o_full&&!ififo_o_full, and SHALL assert l0_wr, ififo_wr and src_rd together in that cycle.
REQ-023 EXEC: inst[3]=inst[1]=1 for len cycles, plus inst[4]=1 in OS; then go to PSUM in OS and to DRAIN in WS.
REQ-024 PSUM (OS only): inst[34]=1 and inst[1:0]=0 for row cycles, then go to DRAIN.
REQ-025 DRAIN: inst[6]=inst[33]=ofifo_valid; it SHALL count reads until len reads in WS and col reads in OS.
REQ-026 DRAIN exit: after the last read, done=1 for one cycle and the FSM returns to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 The counter SHALL be len_bw+1 bits wide and SHALL clear on every state transition.
REQ-030 Count wrap-around SHALL be impossible: terminal counts are compared exactly.
REQ-031 A full-flag stall SHALL freeze the counter; no write SHALL be issued while the target FIFO is full.
REQ-032 All outputs SHALL be registered, taking effect in the cycle after the state decision.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, clear the counters and the latched mode/len, and drive inst, l0_wr, ififo_wr, src_rd, busy and done to 0.
REQ-034 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-035 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-036 Macro CORELET_CTRL_OS_EN defined: OS mode and the PSUM state SHALL be supported.
REQ-037 Macro CORELET_CTRL_OS_EN undefined: mode SHALL be treated as 0, ififo_wr and inst[34:33]/inst[4] SHALL be tied to 0, and PSUM SHALL be unreachable.

Structure
REQ-038 A shared package corelet_ctrl_pkg SHALL hold the state enum and the inst bit-index constants (INST_PSUM=34, INST_ACC=33, INST_OFIFO_RD=6, INST_IFIFO_RD=4, INST_L0_RD=3, INST_EXEC=1, INST_KLOAD=0).
REQ-039 There SHALL be one sub-module, ctrl_counter: a loadable up-counter with enable, clear and a terminal-match output.

Verification
REQ-040 WS run, len=4, row=col=8, src_valid=1, no stalls: 8 l0_wr, then 16 KPUSH cycles, 1 GAP, 4 writes, 4 EXEC cycles; 4 DRAIN reads when ofifo_valid=1; a single done pulse.
REQ-041 OS run, len=3: 3 cycles with l0_wr&ififo_wr together, 3 EXEC cycles with inst[4]=1, 8 PSUM cycles with inst[34]=1, 8 DRAIN reads with acc=1.
REQ-042 l0_o_full held at 1 for 5 cycles during KLOAD: no l0_wr in those cycles, and the write total is still exactly 8.
REQ-043 start with len=0: done on the next cycle and busy never asserts; start pulsed during EXEC is ignored.
REQ-044 reset pulsed low in EXEC: all outputs 0 immediately; a following start with len=2 completes correctly.
REQ-045 Build without CORELET_CTRL_OS_EN, mode=1, len=2: the run follows the WS sequence and ififo_wr stays 0.
